bcd_updown_counter: RTL and testbench



---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit.sv | 37 +++
 rtl/bcd_updown_counter.sv | 96 +++++++++
 tb/tb_bcd_updown_counter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD counter family: digit ceiling,
// widest supported vector and the nibble validity check used on loads.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         DIGITS_MAX = 8;
    localparam int         W_MAX      = 4 * DIGITS_MAX;

    // True when every nibble of a zero-extended packed BCD vector is a decimal digit.
    // Unused upper nibbles are zero and therefore always pass.
    function automatic logic bcd_valid(input logic [W_MAX-1:0] value);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS_MAX; i++) begin
            if (value[4*i +: 4] > BCD_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit stage: steps its nibble by one in the chosen
// direction when a ripple arrives from the digit below, and passes a ripple
// on when it rolls over (9->0 going up, 0->9 going down).
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       up,
    input  logic       step_in,
    output logic [3:0] digit_next,
    output logic       step_out
);

    // Step this digit only when the lower digits rolled over into it.
    always_comb begin
        digit_next = digit;
        step_out   = 1'b0;
        if (step_in) begin
            if (up) begin
                if (digit >= BCD_MAX) begin
                    digit_next = 4'd0;
                    step_out   = 1'b1;
                end else begin
                    digit_next = digit + 4'd1;
                end
            end else begin
                if (digit == 4'd0) begin
                    digit_next = BCD_MAX;
                    step_out   = 1'b1;
                end else begin
                    digit_next = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit packed-BCD up/down counter with run-time init/limit bounds,
// synchronous validated load, and registered carry/borrow/load_err pulses
// for cascading into the next counter stage.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int                  DIGITS  = 2,
    parameter logic [4*DIGITS-1:0] RST_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   init,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  carry,
    output logic                  borrow,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]    stepped;
    logic [DIGITS:0] ripple;
    logic [W-1:0]    bcd_d;
    logic            carry_d;
    logic            borrow_d;
    logic            load_err_d;

    // Digit 0 always steps; each higher digit steps only on a ripple from below.
    assign ripple[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .digit      (bcd[4*g +: 4]),
            .up         (up),
            .step_in    (ripple[g]),
            .digit_next (stepped[4*g +: 4]),
            .step_out   (ripple[g+1])
        );
    end

    // Choose the next count: load beats counting, and out-of-range or
    // chain-overflow positions wrap to the opposite bound with a pulse.
    // A ripple out of the top digit only happens at all-nines/all-zeros,
    // which the bound compare already treats as a wrap; it is folded in so
    // the chain can never silently overflow.
    always_comb begin
        bcd_d      = bcd;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (bcd_valid(W_MAX'(load_val))) begin
                bcd_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if ((bcd >= limit) || ripple[DIGITS]) begin
                    bcd_d   = init;
                    carry_d = 1'b1;
                end else begin
                    bcd_d = stepped;
                end
            end else begin
                if ((bcd <= init) || ripple[DIGITS]) begin
                    bcd_d    = limit;
                    borrow_d = 1'b1;
                end else begin
                    bcd_d = stepped;
                end
            end
        end
    end

    // Register the count together with its pulses so they appear on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd      <= RST_VAL;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            bcd      <= bcd_d;
            carry    <= carry_d;
            borrow   <= borrow_d;
            load_err <= load_err_d;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter: a 2-digit and a 3-digit
// instance run side by side against an integer-arithmetic reference model,
// with directed scenarios followed by randomized stimulus.
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    logic rst;

    logic        en2, up2, load2;
    logic [7:0]  load_val2, init2, limit2, bcd2;
    logic        carry2, borrow2, load_err2;

    logic        en3, up3, load3;
    logic [11:0] load_val3, init3, limit3, bcd3;
    logic        carry3, borrow3, load_err3;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp2;
    logic [31:0] exp3;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2), .RST_VAL(8'h00)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .up(up2), .load(load2),
        .load_val(load_val2), .init(init2), .limit(limit2),
        .bcd(bcd2), .carry(carry2), .borrow(borrow2), .load_err(load_err2)
    );

    bcd_updown_counter #(.DIGITS(3), .RST_VAL(12'h123)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .up(up3), .load(load3),
        .load_val(load_val3), .init(init3), .limit(limit3),
        .bcd(bcd3), .carry(carry3), .borrow(borrow3), .load_err(load_err3)
    );

    function automatic int pow10(input int d);
        int r;
        r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd2int(input logic [31:0] v, input int digits);
        int n;
        n = 0;
        for (int i = digits - 1; i >= 0; i--) n = n * 10 + int'(v[4*i +: 4]);
        return n;
    endfunction

    function automatic logic [31:0] int2bcd(input int value, input int digits);
        logic [31:0] r;
        int          n;
        r = '0;
        n = value;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] randBcd(input int digits);
        return int2bcd(int'($urandom_range(0, pow10(digits) - 1)), digits);
    endfunction

    // Reference: decimal arithmetic on integers, wrap by bound comparison.
    task automatic stepModel(input int digits, input logic [31:0] cur,
                             input logic ld, input logic en, input logic up,
                             input logic [31:0] lv, input logic [31:0] ini,
                             input logic [31:0] lim,
                             output logic [31:0] nxt, output logic c,
                             output logic b, output logic le);
        logic valid;
        int   vc;
        nxt = cur; c = 1'b0; b = 1'b0; le = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < digits; i++)
            if (((lv >> (4 * i)) & 32'hF) > 32'd9) valid = 1'b0;
        if (ld) begin
            if (valid) nxt = lv;
            else le = 1'b1;
        end else if (en) begin
            vc = bcd2int(cur, digits);
            if (up) begin
                if (vc >= bcd2int(lim, digits)) begin nxt = ini; c = 1'b1; end
                else nxt = int2bcd(vc + 1, digits);
            end else begin
                if (vc <= bcd2int(ini, digits)) begin nxt = lim; b = 1'b1; end
                else nxt = int2bcd(vc - 1, digits);
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic ld, input logic en,
                                 input logic up, input logic [31:0] lv,
                                 input logic [31:0] ini, input logic [31:0] lim);
        if (sel == 2) begin
            load2 = ld; en2 = en; up2 = up;
            load_val2 = lv[7:0]; init2 = ini[7:0]; limit2 = lim[7:0];
        end else begin
            load3 = ld; en3 = en; up3 = up;
            load_val3 = lv[11:0]; init3 = ini[11:0]; limit3 = lim[11:0];
        end
    endtask

    // One clock step: predict both instances, advance, then compare.
    task automatic tick();
        logic [31:0] n2, n3;
        logic        c2, b2, l2, c3, b3, l3;
        stepModel(2, exp2, load2, en2, up2, 32'(load_val2), 32'(init2), 32'(limit2),
                  n2, c2, b2, l2);
        stepModel(3, exp3, load3, en3, up3, 32'(load_val3), 32'(init3), 32'(limit3),
                  n3, c3, b3, l3);
        @(posedge clk);
        #1;
        exp2 = n2;
        exp3 = n3;
        checkOutput("bcd2",      32'(bcd2),      exp2);
        checkOutput("carry2",    32'(carry2),    32'(c2));
        checkOutput("borrow2",   32'(borrow2),   32'(b2));
        checkOutput("load_err2", 32'(load_err2), 32'(l2));
        checkOutput("bcd3",      32'(bcd3),      exp3);
        checkOutput("carry3",    32'(carry3),    32'(c3));
        checkOutput("borrow3",   32'(borrow3),   32'(b3));
        checkOutput("load_err3", 32'(load_err3), 32'(l3));
    endtask

    initial begin
        logic [31:0] a, b;
        rst = 1'b1;
        applyStimulus(2, 1'b0, 1'b0, 1'b1, 32'h0, 32'h00, 32'h59);
        applyStimulus(3, 1'b0, 1'b0, 1'b1, 32'h0, 32'h000, 32'h999);
        #3;
        checkOutput("reset_bcd2",   32'(bcd2),   32'h00);
        checkOutput("reset_bcd3",   32'(bcd3),   32'h123);
        checkOutput("reset_carry2", 32'(carry2), 32'h0);
        checkOutput("reset_lerr3",  32'(load_err3), 32'h0);
        exp2 = 32'h00;
        exp3 = 32'h123;
        #7 rst = 1'b0;

        // Up count with wrap at 59 and a 09->10 ripple.
        applyStimulus(2, 1'b1, 1'b1, 1'b1, 32'h57, 32'h00, 32'h59);
        tick();
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 32'h0, 32'h00, 32'h59);
        tick();
        tick();
        checkOutput("up_at_limit", 32'(bcd2), 32'h59);
        tick();
        checkOutput("up_wrap_bcd",   32'(bcd2),  32'h00);
        checkOutput("up_wrap_carry", 32'(carry2), 32'h1);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("ripple_10", 32'(bcd2), 32'h10);

        // Down count with wrap to 59, and 10->09 without borrow.
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'h01, 32'h00, 32'h59);
        tick();
        applyStimulus(2, 1'b0, 1'b1, 1'b0, 32'h0, 32'h00, 32'h59);
        tick();
        tick();
        checkOutput("down_wrap_bcd",    32'(bcd2),    32'h59);
        checkOutput("down_wrap_borrow", 32'(borrow2), 32'h1);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'h10, 32'h00, 32'h59);
        tick();
        applyStimulus(2, 1'b0, 1'b1, 1'b0, 32'h0, 32'h00, 32'h59);
        tick();
        checkOutput("down_ripple_09", 32'(bcd2),    32'h09);
        checkOutput("down_no_borrow", 32'(borrow2), 32'h0);

        // Load beats enable; invalid load is rejected.
        applyStimulus(2, 1'b1, 1'b1, 1'b1, 32'h37, 32'h00, 32'h59);
        tick();
        checkOutput("load_37", 32'(bcd2), 32'h37);
        applyStimulus(2, 1'b1, 1'b1, 1'b1, 32'h3A, 32'h00, 32'h59);
        tick();
        checkOutput("load_bad_hold", 32'(bcd2),      32'h37);
        checkOutput("load_bad_err",  32'(load_err2), 32'h1);

        // Hold at 42 with direction toggling.
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'h42, 32'h00, 32'h59);
        tick();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2, 1'b0, 1'b0, 1'(i), 32'h0, 32'h00, 32'h59);
            tick();
        end
        checkOutput("hold_42", 32'(bcd2), 32'h42);

        // Asynchronous reset mid-cycle at 58.
        applyStimulus(2, 1'b1, 1'b0, 1'b1, 32'h58, 32'h00, 32'h59);
        tick();
        applyStimulus(2, 1'b0, 1'b1, 1'b1, 32'h0, 32'h00, 32'h59);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_bcd2",  32'(bcd2),  32'h00);
        checkOutput("async_rst_bcd3",  32'(bcd3),  32'h123);
        checkOutput("async_rst_carry", 32'(carry2), 32'h0);
        exp2 = 32'h00;
        exp3 = 32'h123;
        #2 rst = 1'b0;
        tick();
        checkOutput("resume_01", 32'(bcd2), 32'h01);
        tick();
        checkOutput("resume_02", 32'(bcd2), 32'h02);
        applyStimulus(2, 1'b0, 1'b0, 1'b1, 32'h0, 32'h00, 32'h59);

        // Three digits: full range wrap, then limit lowered below the count.
        applyStimulus(3, 1'b1, 1'b0, 1'b1, 32'h998, 32'h000, 32'h999);
        tick();
        applyStimulus(3, 1'b0, 1'b1, 1'b1, 32'h0, 32'h000, 32'h999);
        tick();
        checkOutput("d3_999", 32'(bcd3), 32'h999);
        tick();
        checkOutput("d3_wrap_bcd",   32'(bcd3),   32'h000);
        checkOutput("d3_wrap_carry", 32'(carry3), 32'h1);
        applyStimulus(3, 1'b1, 1'b0, 1'b1, 32'h150, 32'h000, 32'h999);
        tick();
        applyStimulus(3, 1'b0, 1'b1, 1'b1, 32'h0, 32'h000, 32'h100);
        tick();
        checkOutput("d3_limit_drop_bcd",   32'(bcd3),   32'h000);
        checkOutput("d3_limit_drop_carry", 32'(carry3), 32'h1);

        // Randomized traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            for (int s = 2; s <= 3; s++) begin
                logic [31:0] lv, ini, lim;
                ini = (s == 2) ? 32'(init2)  : 32'(init3);
                lim = (s == 2) ? 32'(limit2) : 32'(limit3);
                if ($urandom_range(0, 15) == 0) begin
                    a = randBcd(s);
                    b = randBcd(s);
                    if ($urandom_range(0, 7) == 0 || bcd2int(a, s) <= bcd2int(b, s)) begin
                        ini = a; lim = b;
                    end else begin
                        ini = b; lim = a;
                    end
                end
                if ($urandom_range(0, 3) == 0) lv = $urandom & ((s == 2) ? 32'hFF : 32'hFFF);
                else lv = randBcd(s);
                applyStimulus(s, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
                              1'($urandom_range(0, 1)), lv, ini, lim);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
